icache_refill: RTL and testbench
================================

# icache_refill

Line-refill engine for the L1 instruction cache. It accepts a miss address from the fetch side and issues one incrementing read burst on the memory bus for the whole aligned line. It writes each returned beat into the cache's burst write port (`cache_write_en`/`cache_write_addr`/`cache_write_data`), then reports completion and any error status back to fetch.

## Interface
- `LINE_WORDS`, 8: 32-bit words per cache line; power of two, 2..16.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `miss_req`  in  1  fetch requests a line refill.
- `miss_addr`  in  32  faulting fetch address; any byte offset.
- `miss_ready`  out  1  engine idle; a request is accepted when `miss_req && miss_ready`.
- `refill_done`  out  1  one-cycle pulse marking the end of a refill.
- `refill_err`  out  1  valid with `refill_done`; set for a bad response or bad burst length.
- `arvalid`  out  1  read-address valid.
- `araddr`  out  32  line-aligned burst base address.
- `arlen`  out  8  beats minus one; constant `LINE_WORDS-1`.
- `arready`  in  1  bus accepts the address.
- `rvalid`  in  1  read-data valid.
- `rdata`  in  32  read data.
- `rresp`  in  2  response; non-zero means error.
- `rlast`  in  1  final beat of the burst.
- `rready`  out  1  engine accepts a data beat.
- `cache_write_en`  out  1  write one word into the cache line.
- `cache_write_addr`  out  32  word address being written.
- `cache_write_data`  out  32  word being written.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- **IDLE**
  - `miss_ready=1`.
  - On accept: latch `base = miss_addr & ~(4*LINE_WORDS-1)`, clear the beat counter and error flag, go to ADDR.
- **ADDR**
  - `arvalid=1`; `araddr=base`.
  - `arvalid` and `araddr` are held stable until `arready`; then go to DATA.
  - `arvalid` must not drop without a handshake.
- **DATA**
  - `rready=1`.
  - Each handshake (`rvalid && rready`) with count k writes `rdata` to `base + 4*k`, then increments k.
  - The counter is log2(LINE_WORDS)+1 bits wide.
  - Error flag is set when any of these occur:
    - `rresp != 0` on any beat;
    - `rlast=1` with `k != LINE_WORDS-1`;
    - `rlast=0` with `k == LINE_WORDS-1`.
  - Leave DATA on the first beat where `rlast=1` or `k == LINE_WORDS-1`; go to DONE.
  - Erroneous beats are still written. Fetch must not treat the line as valid when `refill_err` is set.
- **DONE**
  - `refill_done=1`, `refill_err` = error flag; go to IDLE.
- `miss_req` while not in IDLE is ignored; `miss_addr` is sampled only at accept.
- Reset in any state:
  - next state IDLE, all registers cleared.
  - An in-flight burst is abandoned; the bus is reset on the same `rst`.

## Timing
- Reset values:
  - 0: `arvalid`, `araddr`, `rready`, `cache_write_en`, `cache_write_addr`, `cache_write_data`, `refill_done`, `refill_err`.
  - 1: `miss_ready` (IDLE).
- `arlen` is constant.
- `miss_ready` and `rready` decode from state only, with no combinational path from bus inputs.
- `cache_write_*` are registered: a beat handshaken in cycle t is written in cycle t+1. `cache_write_en` is otherwise 0.
- The last beat at cycle t gives the last write and `refill_done` both in cycle t+1 (DONE). `miss_ready` rises in t+2.
- Minimum latency, with `arready` and `rvalid` held high and `LINE_WORDS`=8:
  - accept at cycle 0;
  - `arvalid` in cycle 1;
  - beats in cycles 2–9;
  - writes in cycles 3–10;
  - `refill_done` in cycle 10;
  - next accept in cycle 11.
- Bus stalls (`arready=0`, `rvalid=0`) extend ADDR or DATA indefinitely with no writes and no state loss.

## Test plan
- **Basic refill:** `miss_addr`=0x0000_1234, `rdata` = 0xA0..0xA7, bus always ready.
  - `araddr`=0x0000_1220, `arlen`=7.
  - Writes (0x1220,0xA0)…(0x123C,0xA7) in cycles 3–10.
  - `refill_done`=1 and `refill_err`=0 in cycle 10.
- **Stalls:** `arready` low for 3 cycles; `rvalid` toggled 1,0,1,0….
  - Exactly 8 writes, ascending addresses, data matched per beat.
  - `arvalid`/`araddr` stable while stalled.
- **Error response:** `rresp`=2 on beat 3.
  - All 8 beats still written; `refill_done` pulses with `refill_err`=1.
- **Bad length:** `rlast` on beat 5.
  - 6 writes, then DONE with `refill_err`=1.
  - Separately, no `rlast` on beat 7: 8 writes, `refill_err`=1.
- **Busy and back-to-back:** `miss_req` held high through a refill.
  - Second request accepted only in the cycle after `refill_done`.
  - `miss_addr` changes during the refill are ignored.
- **Reset mid-burst:** `rst` asserted after beat 4.
  - Next cycle: all outputs at reset values, `miss_ready`=1, no further writes.
  - A fresh refill then completes normally.

Source files
------------

// File: rtl/icache_refill.sv
// L1 instruction-cache line-refill engine: one incrementing read burst per miss,
// each returned beat written into the cache line, completion/error back to fetch.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   miss_req/miss_addr        refill request from fetch (accepted with miss_ready)
//   miss_ready                engine idle
//   refill_done/refill_err    one-cycle completion pulse and its error status
//   arvalid/araddr/arlen      read-address channel (line-aligned, LINE_WORDS beats)
//   arready                   bus accepts the address
//   rvalid/rdata/rresp/rlast  read-data channel from the bus
//   rready                    engine accepts a data beat
//   cache_write_*             registered cache line write port, one word per beat
module icache_refill #(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        miss_req,
    input  logic [31:0] miss_addr,
    output logic        miss_ready,
    output logic        refill_done,
    output logic        refill_err,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        rready,
    output logic        cache_write_en,
    output logic [31:0] cache_write_addr,
    output logic [31:0] cache_write_data
);

    localparam int CW = $clog2(LINE_WORDS) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
    localparam logic [31:0] OFF_MASK = 32'(4 * LINE_WORDS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]    state;
    logic [31:0]   base;
    logic [CW-1:0] cnt;
    logic          err;
    logic          at_last;
    logic          bad_beat;
    logic [31:0]   beat_off;

    assign at_last = (cnt == LAST_BEAT);
    // rlast must coincide exactly with the final counted beat.
    assign bad_beat = (rresp != 2'b00) || (rlast != at_last);
    assign beat_off = 32'({cnt, 2'b00});

    // Handshake-side outputs decode from state only.
    assign miss_ready  = (state == S_IDLE);
    assign arvalid     = (state == S_ADDR);
    assign rready      = (state == S_DATA);
    assign refill_done = (state == S_DONE);
    assign refill_err  = (state == S_DONE) && err;
    assign araddr      = base;
    assign arlen       = 8'(LINE_WORDS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            base             <= '0;
            cnt              <= '0;
            err              <= 1'b0;
            cache_write_en   <= 1'b0;
            cache_write_addr <= '0;
            cache_write_data <= '0;
        end else begin
            cache_write_en <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (miss_req) begin
                        base  <= miss_addr & ~OFF_MASK;
                        cnt   <= '0;
                        err   <= 1'b0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (arready) state <= S_DATA;
                end
                S_DATA: begin
                    if (rvalid) begin
                        // Erroneous beats are still written; refill_err
                        // tells fetch not to trust the line.
                        cache_write_en   <= 1'b1;
                        cache_write_addr <= base + beat_off;
                        cache_write_data <= rdata;
                        cnt              <= cnt + 1'b1;
                        if (bad_beat) err <= 1'b1;
                        if (rlast || at_last) state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: basic refill, stalls, error response,
// bad burst length, busy/back-to-back requests and reset mid-burst.
module tb_icache_refill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        miss_req = 1'b0;
    logic [31:0] miss_addr = '0;
    logic        miss_ready;
    logic        refill_done;
    logic        refill_err;
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        arready = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rlast = 1'b0;
    logic        rready;
    logic        cache_write_en;
    logic [31:0] cache_write_addr;
    logic [31:0] cache_write_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];

    icache_refill #(.LINE_WORDS(8)) dut (
        .clk(clk), .rst(rst),
        .miss_req(miss_req), .miss_addr(miss_addr),
        .miss_ready(miss_ready),
        .refill_done(refill_done), .refill_err(refill_err),
        .arvalid(arvalid), .araddr(araddr), .arlen(arlen),
        .arready(arready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rready(rready),
        .cache_write_en(cache_write_en),
        .cache_write_addr(cache_write_addr),
        .cache_write_data(cache_write_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cache_write_en) begin
            wa_q.push_back(cache_write_addr);
            wd_q.push_back(cache_write_data);
            wc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miss_ready"}, miss_ready, 1);
        check({tag, "_arvalid"}, arvalid, 0);
        check({tag, "_araddr"}, araddr, 0);
        check({tag, "_rready"}, rready, 0);
        check({tag, "_wen"}, cache_write_en, 0);
        check({tag, "_waddr"}, cache_write_addr, 0);
        check({tag, "_wdata"}, cache_write_data, 0);
        check({tag, "_done"}, refill_done, 0);
        check({tag, "_err"}, refill_err, 0);
    endtask

    // One refill from IDLE; returns in the IDLE cycle after DONE.
    task automatic do_refill(input logic [31:0] addr, input logic [31:0] exp_base,
                             input int ar_stall, input bit toggle,
                             input int err_beat, input int last_beat,
                             input int nbeats, input bit hold,
                             input bit exp_err, input bit timing);
        int c_acc;
        int beat;
        bit phase;
        clear_writes();
        check("start_idle", miss_ready, 1);
        miss_req  = 1'b1;
        miss_addr = addr;
        c_acc = cyc;
        step();
        miss_req = hold;
        if (hold) miss_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < ar_stall; i++) begin
            arready = 1'b0;
            check("stall_arvalid", arvalid, 1);
            check("stall_araddr", araddr, exp_base);
            step();
            if (hold) miss_addr = miss_addr - 32'h100;
        end
        arready = 1'b1;
        check("arvalid", arvalid, 1);
        check("araddr", araddr, exp_base);
        check("arlen", arlen, 7);
        check("busy_ready", miss_ready, 0);
        step();
        arready = 1'b0;
        beat  = 0;
        phase = 1'b1;
        for (int n = 0; n < 200 && beat < nbeats; n++) begin
            rvalid = toggle ? phase : 1'b1;
            phase  = ~phase;
            rdata  = rvalid ? 32'(32'hA0 + beat) : 32'hDEAD_BEEF;
            rresp  = (rvalid && beat == err_beat) ? 2'd2 : 2'd0;
            rlast  = rvalid && (beat == last_beat);
            check("rready", rready, 1);
            check("data_araddr", araddr, exp_base);
            if (hold) miss_addr = miss_addr ^ 32'h0F0F_0000;
            step();
            if (rvalid) beat++;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'd0;
        if (beat < nbeats) check("data_timeout", 0, 1);
        check("done", refill_done, 1);
        check("done_err", refill_err, exp_err);
        check("done_ready", miss_ready, 0);
        check("done_rready", rready, 0);
        if (timing) check("done_cycle", cyc, c_acc + 10);
        step();
        check("idle_done", refill_done, 0);
        check("idle_ready", miss_ready, 1);
        check("idle_arvalid", arvalid, 0);
        check("idle_wen", cache_write_en, 0);
        check("wr_count", wa_q.size(), nbeats);
        for (int i = 0; i < wa_q.size() && i < nbeats; i++) begin
            check("wr_addr", wa_q[i], exp_base + 32'(4 * i));
            check("wr_data", wd_q[i], 32'(32'hA0 + i));
        end
        if (timing && wc_q.size() > 0) begin
            check("wr_first_cycle", wc_q[0], c_acc + 3);
            check("wr_last_cycle", wc_q[wc_q.size() - 1], c_acc + 10);
        end
    endtask

    initial begin
        repeat (3) step();
        check_reset_outputs("rst");
        check("rst_arlen", arlen, 7);
        rst = 1'b0;
        step();

        // Basic refill, bus always ready.
        do_refill(32'h0000_1234, 32'h0000_1220, 0, 0, -1, 7, 8, 0, 0, 1);
        // arready stalled 3 cycles, rvalid toggling.
        do_refill(32'h8000_0044, 32'h8000_0040, 3, 1, -1, 7, 8, 0, 0, 0);
        // Error response on beat 3.
        do_refill(32'h2000_001C, 32'h2000_0000, 0, 0, 3, 7, 8, 0, 1, 0);
        // Early rlast on beat 5.
        do_refill(32'h3000_0020, 32'h3000_0020, 0, 0, -1, 5, 6, 0, 1, 0);
        // Missing rlast on beat 7.
        do_refill(32'h3000_0047, 32'h3000_0040, 0, 0, -1, -1, 8, 0, 1, 0);
        // miss_req held through a refill with a wandering address.
        do_refill(32'h4000_0104, 32'h4000_0100, 0, 0, -1, 7, 8, 1, 0, 1);
        do_refill(32'h4000_0208, 32'h4000_0200, 0, 0, -1, 7, 8, 0, 0, 1);

        // Reset mid-burst after four beats.
        clear_writes();
        miss_req  = 1'b1;
        miss_addr = 32'h5000_0010;
        step();
        miss_req = 1'b0;
        arready  = 1'b1;
        step();
        arready = 1'b0;
        rvalid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rdata = 32'(32'hC0 + i);
            step();
        end
        check("pre_rst_writes", wa_q.size(), 3);
        rst = 1'b1;
        step();
        rst    = 1'b0;
        rvalid = 1'b0;
        check_reset_outputs("midrst");
        clear_writes();
        step();
        step();
        check("post_rst_writes", wa_q.size(), 0);
        do_refill(32'h6000_003F, 32'h6000_0020, 0, 0, -1, 7, 8, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
